controle_vedacao: RTL

- Corking-station sequencer on the wine conveyor.
- Stops the belt when a bottle reaches the corking position and checks that the bottle is filled and a cork is available.
- Drives the corking actuator, then pulses `dec` once per sealed bottle to the cork counter downstream of its cork request, and releases the bottle.
- Consumes `rolha_disponivel` and `LED_Alarme` from the cork counter; produces its `dec`.

---
 rtl/vinho_pkg.sv | 21 ++
 rtl/sincronizador.sv | 22 ++
 rtl/controle_vedacao.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vinho_pkg.sv
// Shared types and default timing for the wine-line stages.
// Provides the corking FSM state enum, default timers and counter width.
package vinho_pkg;

  localparam int CNT_W        = 8;
  localparam int T_ASSENTA    = 4;
  localparam int T_VEDACAO    = 8;
  localparam int T_LIBERA_MAX = 16;
  localparam int TMR_W        = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRANSPORTE = 3'd1,
    POSICIONA  = 3'd2,
    SEM_ROLHA  = 3'd3,
    VEDANDO    = 3'd4,
    LIBERA     = 3'd5,
    ERRO       = 3'd6
  } estado_t;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for asynchronous sensor inputs.
// Ports: clk, reset (async active-low), d (async in), q (synchronized out).
module sincronizador (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/controle_vedacao.sv
// Corking-station sequencer: stop belt, check fill/cork, press, release.
// Ports: line/sensor/cork inputs; motor, press, dec, reject, fault, counts.
module controle_vedacao
  import vinho_pkg::*;
#(
  parameter int T_ASSENTA    = vinho_pkg::T_ASSENTA,
  parameter int T_VEDACAO    = vinho_pkg::T_VEDACAO,
  parameter int T_LIBERA_MAX = vinho_pkg::T_LIBERA_MAX,
  parameter int CNT_W        = vinho_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ligar,
  input  logic             sensor_garrafa,
  input  logic             garrafa_cheia,
  input  logic             rolha_disponivel,
  input  logic             LED_Alarme,
  input  logic             limpa_erro,
  output logic             motor_esteira,
  output logic             atuador_vedacao,
  output logic             dec,
  output logic             rejeita,
  output logic             aguardando_rolha,
  output logic             erro,
  output logic [CNT_W-1:0] garrafas_vedadas,
  output logic [CNT_W-1:0] garrafas_rejeitadas
);

  estado_t          state, nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             sens_s;
  logic             rej_nxt;
  logic             motor_d, atua_d, dec_d, aguarda_d, erro_d;

  sincronizador u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sensor_garrafa),
    .q     (sens_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    nxt     = state;
    tmr_nxt = '0;
    rej_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (ligar) nxt = TRANSPORTE;
      end
      TRANSPORTE: begin
        if (!ligar)      nxt = IDLE;
        else if (sens_s) nxt = POSICIONA;
      end
      POSICIONA: begin
        if (!sens_s) begin
          nxt = TRANSPORTE;
        end else if (tmr == TMR_W'(T_ASSENTA - 1)) begin
          if (!garrafa_cheia) begin
            nxt     = LIBERA;
            rej_nxt = 1'b1;
          end else if (!rolha_disponivel) begin
            nxt = SEM_ROLHA;
          end else begin
            nxt = VEDANDO;
          end
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      SEM_ROLHA: begin
        if (rolha_disponivel) nxt = VEDANDO;
        else if (LED_Alarme)  nxt = ERRO;
      end
      VEDANDO: begin
        if (tmr == TMR_W'(T_VEDACAO - 1)) nxt = LIBERA;
        else tmr_nxt = tmr + 1'b1;
      end
      LIBERA: begin
        if (!sens_s) begin
          nxt = ligar ? TRANSPORTE : IDLE;
        end else if (tmr == TMR_W'(T_LIBERA_MAX - 1)) begin
          nxt = ERRO;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      ERRO: begin
        if (limpa_erro && !sens_s) nxt = IDLE;
      end
      default: nxt = ERRO;
    endcase
  end

  // Outputs are decoded from the upcoming state and registered, so each
  // output is aligned with the cycle spent in that state; dec lands on
  // the final press cycle.
  always_comb begin
    motor_d   = (nxt == TRANSPORTE) || (nxt == LIBERA);
    atua_d    = (nxt == VEDANDO);
    aguarda_d = (nxt == SEM_ROLHA);
    erro_d    = (nxt == ERRO);
    dec_d     = (nxt == VEDANDO) &&
                (tmr_nxt == TMR_W'(T_VEDACAO - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      motor_esteira       <= 1'b0;
      atuador_vedacao     <= 1'b0;
      dec                 <= 1'b0;
      rejeita             <= 1'b0;
      aguardando_rolha    <= 1'b0;
      erro                <= 1'b0;
      garrafas_vedadas    <= '0;
      garrafas_rejeitadas <= '0;
    end else begin
      motor_esteira    <= motor_d;
      atuador_vedacao  <= atua_d;
      dec              <= dec_d;
      rejeita          <= rej_nxt;
      aguardando_rolha <= aguarda_d;
      erro             <= erro_d;
      if (dec_d && !(&garrafas_vedadas))
        garrafas_vedadas <= garrafas_vedadas + 1'b1;
      if (rej_nxt && !(&garrafas_rejeitadas))
        garrafas_rejeitadas <= garrafas_rejeitadas + 1'b1;
    end
  end

endmodule
